// File: rtl/ft60x_fifo_slave.sv
// rtl/ft60x_fifo_slave.sv - FT600/FT601 245-style synchronous FIFO slave with packet buffers
//
// Purpose: presents a slave FIFO to an FT60x-style bus master. Words arriving on
// s_axis are buffered and read out by the master; words written by the master are
// buffered and forwarded on m_axis, with tlast marking the end of each write burst.
//
// Ports:
//   usb_clk, rst_usbclk         clock, synchronous active-high reset
//   usb_rstn                    bus-master reset, active-low, sampled on usb_clk
//   usb_wr_n/usb_rd_n/usb_oe_n  master strobes
//   usb_txe_n/usb_rxf_n         slave flow-control flags (registered)
//   usb_data_i/usb_be_i         write data / byte enables from master
//   usb_data_o/usb_be_o         read data / byte enables to master
//   usb_data_t/usb_be_t         tristate controls, 0 = slave drives
//   s_axis_*                    host-to-master packet stream
//   m_axis_*                    master-to-host packet stream
//   err_flags                   sticky [0] overflow, [1] underflow, [2] bus conflict

module ft60x_fifo_slave #(
    parameter int FIFO_BUS_WIDTH = 2,
    parameter int BUF_DEPTH      = 64,
    parameter int TXE_MARGIN     = 4,
    parameter int RXF_GAP        = 2
) (
    input  logic                        usb_clk,
    input  logic                        rst_usbclk,
    input  logic                        usb_rstn,
    input  logic                        usb_wr_n,
    input  logic                        usb_rd_n,
    input  logic                        usb_oe_n,
    output logic                        usb_txe_n,
    output logic                        usb_rxf_n,
    input  logic [FIFO_BUS_WIDTH*8-1:0] usb_data_i,
    input  logic [FIFO_BUS_WIDTH-1:0]   usb_be_i,
    output logic [FIFO_BUS_WIDTH*8-1:0] usb_data_o,
    output logic [FIFO_BUS_WIDTH-1:0]   usb_be_o,
    output logic                        usb_data_t,
    output logic                        usb_be_t,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    input  logic [FIFO_BUS_WIDTH*8-1:0] s_axis_tdata,
    input  logic [FIFO_BUS_WIDTH-1:0]   s_axis_tkeep,
    input  logic                        s_axis_tlast,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic [FIFO_BUS_WIDTH*8-1:0] m_axis_tdata,
    output logic [FIFO_BUS_WIDTH-1:0]   m_axis_tkeep,
    output logic                        m_axis_tlast,
    output logic [2:0]                  err_flags
);

    localparam int DW = FIFO_BUS_WIDTH * 8;
    localparam int BW = FIFO_BUS_WIDTH;
    localparam int EW = DW + BW + 1;          // entry = {last, be, data}
    localparam int AW = $clog2(BUF_DEPTH);
    localparam int CW = AW + 1;
    localparam int GW = (RXF_GAP < 2) ? 1 : $clog2(RXF_GAP + 1);

    typedef enum logic [1:0] {ST_IN, ST_TURN, ST_OUT} state_t;

    logic              rst;
    state_t            state_q, state_d;
    logic              data_t_q;

    logic [EW-1:0]     rbuf_q [BUF_DEPTH];
    logic [EW-1:0]     wbuf_q [BUF_DEPTH];
    logic [AW-1:0]     rrd_q, rwr_q, rrd_d;
    logic [AW-1:0]     wrd_q, wwr_q;
    logic [CW-1:0]     rcnt_q, rcnt_d, wcnt_q, wcnt_d;
    logic              tready_q, rxf_n_q, txe_n_q;
    logic [DW-1:0]     data_o_q;
    logic [BW-1:0]     be_o_q;
    logic [GW-1:0]     gap_q, gap_d;
    logic              hold_vld_q;
    logic [DW-1:0]     hold_data_q;
    logic [BW-1:0]     hold_be_q;
    logic [2:0]        err_q;

    logic              r_push, r_rd_req, r_pop, r_under;
    logic [EW-1:0]     r_in;
    logic [DW+BW-1:0]  r_next_head;
    logic              w_wr, w_conflict, w_full, w_pop, w_accept, w_over;
    logic [EW-1:0]     w_head;

    assign rst = rst_usbclk | ~usb_rstn;

    // Read direction: s_axis -> buffer -> bus
    assign r_in     = {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
    assign r_push   = s_axis_tvalid & tready_q;
    assign r_rd_req = (state_q == ST_OUT) & ~usb_rd_n;
    assign r_pop    = r_rd_req & (rcnt_q != '0);
    assign r_under  = r_rd_req & (rcnt_q == '0);
    assign rrd_d    = rrd_q + AW'(r_pop);
    assign rcnt_d   = rcnt_q + CW'(r_push) - CW'(r_pop);

    // Next bus-side head; when the buffer drains to the word being pushed this
    // cycle, that word is not yet in memory and must be forwarded.
    always_comb begin
        r_next_head = rbuf_q[rrd_d][DW+BW-1:0];
        if (r_push && (rrd_d == rwr_q)) begin
            r_next_head = r_in[DW+BW-1:0];
        end
    end

    always_comb begin
        gap_d = gap_q;
        if (r_pop && rbuf_q[rrd_q][EW-1]) begin
            gap_d = GW'(RXF_GAP);
        end else if (gap_q != '0) begin
            gap_d = gap_q - GW'(1);
        end
    end

    // Write direction: bus -> hold register -> buffer -> m_axis
    assign w_wr       = ~usb_wr_n & usb_oe_n;
    assign w_conflict = ~usb_wr_n & ~usb_oe_n;
    assign w_head     = wbuf_q[wrd_q];
    assign w_full     = (wcnt_q == CW'(BUF_DEPTH));
    assign w_pop      = m_axis_tvalid & m_axis_tready;
    assign w_accept   = hold_vld_q & (~w_full | w_pop);
    assign w_over     = hold_vld_q & ~w_accept;
    assign wcnt_d     = wcnt_q + CW'(w_accept) - CW'(w_pop);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IN:   if (!usb_oe_n) state_d = ST_TURN;
            ST_TURN: state_d = usb_oe_n ? ST_IN : ST_OUT;
            ST_OUT:  if (usb_oe_n) state_d = ST_IN;
            default: state_d = ST_IN;
        endcase
    end

    // Buffer storage carries no reset; emptiness is defined by the pointers.
    always_ff @(posedge usb_clk) begin
        if (r_push) rbuf_q[rwr_q] <= r_in;
        // last is decided at push time: the burst ended if wr_n is high now
        if (w_accept) wbuf_q[wwr_q] <= {usb_wr_n, hold_be_q, hold_data_q};
    end

    always_ff @(posedge usb_clk) begin
        if (rst) begin
            state_q     <= ST_IN;
            data_t_q    <= 1'b1;
            rrd_q       <= '0;
            rwr_q       <= '0;
            rcnt_q      <= '0;
            wrd_q       <= '0;
            wwr_q       <= '0;
            wcnt_q      <= '0;
            tready_q    <= 1'b0;
            rxf_n_q     <= 1'b1;
            txe_n_q     <= 1'b1;
            data_o_q    <= '0;
            be_o_q      <= '0;
            gap_q       <= '0;
            hold_vld_q  <= 1'b0;
            hold_data_q <= '0;
            hold_be_q   <= '0;
            err_q       <= '0;
        end else begin
            state_q  <= state_d;
            data_t_q <= (state_d != ST_OUT);
            rrd_q    <= rrd_d;
            rwr_q    <= rwr_q + AW'(r_push);
            rcnt_q   <= rcnt_d;
            tready_q <= (rcnt_d != CW'(BUF_DEPTH));
            if (rcnt_d != '0) begin
                data_o_q <= r_next_head[DW-1:0];
                be_o_q   <= r_next_head[DW+BW-1:DW];
            end
            gap_q   <= gap_d;
            rxf_n_q <= !((rcnt_d != '0) && (gap_d == '0));

            hold_vld_q <= w_wr;
            if (w_wr) begin
                hold_data_q <= usb_data_i;
                hold_be_q   <= usb_be_i;
            end
            wrd_q   <= wrd_q + AW'(w_pop);
            wwr_q   <= wwr_q + AW'(w_accept);
            wcnt_q  <= wcnt_d;
            txe_n_q <= ((CW'(BUF_DEPTH) - wcnt_d) <= CW'(TXE_MARGIN));
            err_q   <= err_q | {w_conflict, r_under, w_over};
        end
    end

    assign usb_txe_n     = txe_n_q;
    assign usb_rxf_n     = rxf_n_q;
    assign usb_data_o    = data_o_q;
    assign usb_be_o      = be_o_q;
    assign usb_data_t    = data_t_q;
    assign usb_be_t      = data_t_q;
    assign s_axis_tready = tready_q;
    assign m_axis_tvalid = (wcnt_q != '0);
    assign m_axis_tdata  = w_head[DW-1:0];
    assign m_axis_tkeep  = w_head[DW+BW-1:DW];
    assign m_axis_tlast  = m_axis_tvalid & w_head[EW-1];
    assign err_flags     = err_q;

endmodule

// File: doc/ft60x_fifo_slave.md
FT60X_FIFO_SLAVE -- requirements
Module: ft60x_fifo_slave

Interface
REQ-001 SHALL have parameter FIFO_BUS_WIDTH, default 2, meaning bus width in bytes (2 = FT600, 4 = FT601).
REQ-002 SHALL have parameter BUF_DEPTH, default 64, meaning words per internal buffer (power of 2, 16-1024).
REQ-003 SHALL have parameter TXE_MARGIN, default 4, meaning free-word margin at or below which usb_txe_n is deasserted.
REQ-004 SHALL have parameter RXF_GAP, default 2, meaning minimum cycles usb_rxf_n is held high after a packet's last word is read.
REQ-005 SHALL have the following ports, listed as name, direction, width, meaning:
- usb_clk, in, 1: sole clock.
- rst_usbclk, in, 1: reset; synchronous, active-high.
- usb_rstn, in, 1: reset from the bus master; active-low, sampled synchronously.
- usb_wr_n, in, 1: master write strobe.
- usb_rd_n, in, 1: master read strobe.
- usb_oe_n, in, 1: master output-enable request.
- usb_txe_n, out, 1: low = slave can accept writes.
- usb_rxf_n, out, 1: low = slave has read data.
- usb_data_i, in, FIFO_BUS_WIDTH*8: write data from master.
- usb_be_i, in, FIFO_BUS_WIDTH: write byte enables from master.
- usb_data_o, out, FIFO_BUS_WIDTH*8: read data to master.
- usb_be_o, out, FIFO_BUS_WIDTH: read byte enables to master.
- usb_data_t, out, 1: data tristate; 0 = slave drives.
- usb_be_t, out, 1: byte-enable tristate; always equals usb_data_t.
- s_axis_tvalid, in, 1; s_axis_tready, out, 1; s_axis_tdata, in, FIFO_BUS_WIDTH*8; s_axis_tkeep, in, FIFO_BUS_WIDTH; s_axis_tlast, in, 1: host-to-master packets.
- m_axis_tvalid, out, 1; m_axis_tready, in, 1; m_axis_tdata, out, FIFO_BUS_WIDTH*8; m_axis_tkeep, out, FIFO_BUS_WIDTH; m_axis_tlast, out, 1: master-to-host packets.
- err_flags, out, 3: sticky error bits; [0] write overflow, [1] read underflow, [2] bus conflict.

Function
REQ-006 SHALL contain a read buffer (s_axis to bus) and a write buffer (bus to m_axis), each BUF_DEPTH entries of {data, be/keep, last}, first-word-fall-through.
REQ-007 SHALL drive s_axis_tready = 1 when the read buffer is not full; a beat is stored on tvalid&tready.
REQ-008 SHALL register usb_rxf_n from post-update state: low iff read buffer non-empty and no RXF_GAP countdown active.
REQ-009 SHALL implement bus-direction FSM IN -> TURN -> OUT:
- IN to TURN on an edge sampling usb_oe_n=0.
- TURN to OUT on the next edge if usb_oe_n is still 0, otherwise back to IN.
- OUT to IN on any edge sampling usb_oe_n=1.
REQ-010 SHALL drive usb_data_t = usb_be_t = 0 only in OUT.
REQ-011 SHALL present the read-buffer head on usb_data_o/usb_be_o continuously, holding the last value when the buffer is empty.
REQ-012 SHALL pop the read buffer on each edge with FSM=OUT and usb_rd_n=0 and buffer non-empty; usb_data_o advances in the following cycle.
REQ-013 SHALL set err_flags[1] on an edge with FSM=OUT and usb_rd_n=0 and read buffer empty; no pop occurs.
REQ-014 SHALL start an RXF_GAP-cycle countdown when a word with last=1 is popped.
REQ-015 SHALL capture a write on each edge with usb_wr_n=0 and usb_oe_n=1 into a one-word hold register.
REQ-016 SHALL push the held word to the write buffer on the next edge, with last = (usb_wr_n sampled 1 at that edge).
REQ-017 SHALL set err_flags[0] and discard the word when a push finds the write buffer full.
REQ-018 SHALL register usb_txe_n from post-update state: high iff write-buffer free words <= TXE_MARGIN.
REQ-019 SHALL ignore any write on an edge sampling usb_wr_n=0 and usb_oe_n=0, and set err_flags[2].
REQ-020 SHALL present the write-buffer head on m_axis with m_axis_tkeep = captured usb_be_i, popping on tvalid&tready.
REQ-021 SHALL allow simultaneous push and pop on either buffer in one cycle, with occupancy unchanged.

Reset
REQ-022 SHALL, while rst_usbclk=1 or usb_rstn=0, hold the following values:
- usb_txe_n=1, usb_rxf_n=1, usb_data_t=1, usb_be_t=1.
- usb_data_o=0, usb_be_o=0.
- s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0.
- err_flags=0, FSM=IN, both buffers and the hold register empty, gap counter 0.
REQ-023 SHALL treat reset asserted mid-burst as an immediate flush, with no partial packet emitted afterwards.

Verification
REQ-024 SHALL be verified by the following directed scenarios (FIFO_BUS_WIDTH=2 unless stated):
- Reset: assert rst_usbclk for 3 cycles -> all REQ-022 values observed; one cycle after release, usb_txe_n=0 and s_axis_tready=1.
- Read packet: s_axis sends 0x1111, 0x2222, 0x3333 (tlast on third); usb_oe_n=0, then usb_rd_n=0 for 3 cycles once usb_data_t=0 -> usb_data_o shows 0x1111, 0x2222, 0x3333; usb_rxf_n goes high and stays high for >= 2 cycles.
- Write burst: usb_wr_n=0 for 4 cycles with data 0xA0A0..0xA3A3 and usb_be_i=11,11,11,01 -> m_axis carries 4 beats, tlast only on 0xA3A3 with tkeep=01.
- Write backpressure: BUF_DEPTH=16, TXE_MARGIN=4, m_axis_tready=0; write 17 words -> usb_txe_n=1 once 12 words are stored; 17th word dropped, err_flags=001.
- Conflict and underflow: usb_wr_n=0 together with usb_oe_n=0 -> no m_axis beat, err_flags[2]=1; usb_rd_n=0 in OUT with read buffer empty -> err_flags[1]=1.
- Mid-burst reset: usb_rstn=0 during a 2-word write -> m_axis_tvalid=0 and no beat emitted after release.
